alu_arbiter: RTL

Shares one `alu` instance between two requesters (e.g. the execute stage and a debug/test port) in the reduced RISC-V core. Accepts at most one operation at a time through per-requester valid/ready request channels, arbitrates round-robin when both request, evaluates the operation in the registered ALU stage, and returns result, equality flag and illegal-opcode error on a shared response bus qualified by per-requester response valid/ready.

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single registered ALU stage.
// One operation in flight at a time: IDLE accepts, EXEC evaluates, RESP holds the response until consumed.

module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            ctrl,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  output logic                  err
);

  // Opcode decode; reserved opcodes yield zero with the error flag raised
  always_comb begin
    result = {DATA_WIDTH{1'b0}};
    err    = 1'b0;
    eq     = (a == b);
    case (ctrl)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      default: begin
        result = {DATA_WIDTH{1'b0}};
        err    = 1'b1;
      end
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2:0]            req0_ctrl,
  input  logic [2:0]            req1_ctrl,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_eq,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    last_grant_r;
  logic                    grant_s;
  logic                    accept_s;
  logic [2:0]              ctrl_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [DATA_WIDTH-1:0]   alu_result_s;
  logic                    alu_eq_s;
  logic                    alu_err_s;
  logic [1:0]              owner_onehot_s;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .ctrl   (ctrl_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result_s),
    .eq     (alu_eq_s),
    .err    (alu_err_s)
  );

  // last_grant_r always names the owner of the transaction in flight
  assign owner_onehot_s = last_grant_r ? 2'b10 : 2'b01;
  assign busy           = (state_r != IDLE);

  // Next-state, arbitration and combinational accept handshake
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = 2'b00;
    accept_s    = 1'b0;
    grant_s     = last_grant_r;
    case (state_r)
      IDLE: begin
        if (req_valid != 2'b00) begin
          // Contention goes to whoever did not win last time
          grant_s            = (req_valid == 2'b11) ? ~last_grant_r : req_valid[1];
          accept_s           = 1'b1;
          req_ready[grant_s] = 1'b1;
          state_nxt_s        = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready[last_grant_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant history and operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      ctrl_r       <= 3'b000;
      a_r          <= {DATA_WIDTH{1'b0}};
      b_r          <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        last_grant_r <= grant_s;
        ctrl_r       <= grant_s ? req1_ctrl : req0_ctrl;
        a_r          <= grant_s ? req1_a    : req0_a;
        b_r          <= grant_s ? req1_b    : req0_b;
      end
    end
  end

  // Response registers: loaded in EXEC, held stable through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 2'b00;
      rsp_result <= {DATA_WIDTH{1'b0}};
      rsp_eq     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt_s == RESP) ? owner_onehot_s : 2'b00;
      if (state_r == EXEC) begin
        rsp_result <= alu_result_s;
        rsp_eq     <= alu_eq_s;
        rsp_err    <= alu_err_s;
      end
    end
  end

endmodule
